fp_mac_pipe_stage: RTL and testbench
====================================

FP_MAC_PIPE_STAGE -- requirements
Module: fp_mac_pipe_stage

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent-sum payload width.
REQ-002 The block SHALL have parameter PROD_W, default 22, meaning significand-product payload width.
REQ-003 The block SHALL use exactly one clock; reset SHALL be asynchronous and active-low.
REQ-004 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clock  input  1  rising-edge clock, sole clock domain
- resetn  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept a payload
- in_out_sign  input  1  product sign
- in_ex_add_out  input  EXP_W  exponent sum
- in_sig_mul_out  input  PROD_W  significand product
- out_valid  output  1  downstream payload valid
- out_ready  input  1  downstream accepts
- out_out_sign  output  1  registered sign
- out_ex_add_out  output  EXP_W  registered exponent sum
- out_sig_mul_out  output  PROD_W  registered product
- out_zero  output  1  registered flag: product equal to zero

Function
REQ-005 The handshakes SHALL be defined as in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-006 The stage SHALL be a 2-entry skid buffer (main and skid registers) controlled by states EMPTY, BUSY and FULL.
REQ-007 Output port values SHALL be:
- out_valid is 1 in BUSY and FULL
- in_ready is 1 in EMPTY and BUSY
- both SHALL be decoded from state registers only, with no combinational path from out_ready or in_valid.
REQ-008 EMPTY transitions SHALL be:
- on in_fire, load main and go to BUSY
- otherwise stay in EMPTY.
REQ-009 BUSY transitions SHALL be:
- on in_fire & out_fire, load main and stay in BUSY
- on in_fire & !out_fire, load skid and go to FULL
- on !in_fire & out_fire, go to EMPTY
- otherwise hold.
REQ-010 FULL transitions SHALL be:
- on out_fire, copy skid to main and go to BUSY
- otherwise hold.
REQ-011 Latency SHALL be 1 cycle from in_fire to out_valid when empty, and sustained throughput SHALL be 1 payload per cycle while out_ready=1.
REQ-012 Payload order SHALL be preserved, with no payload dropped or duplicated except by flush.
REQ-013 Output data and out_zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 out_zero SHALL be computed as (in_sig_mul_out == 0) at capture and stored alongside its payload, in either main or skid.
REQ-015 Flush SHALL have highest priority: flush=1 forces state to EMPTY next cycle, and any same-cycle in_fire payload SHALL be discarded.
REQ-016 During flush, data registers SHALL keep their values; only state changes.
REQ-017 Payload fields SHALL pass unmodified, with no arithmetic, width change or sign extension.

Reset
REQ-018 On resetn=0 the block SHALL asynchronously force:
- state to EMPTY
- out_valid=0 and in_ready=1
- out_out_sign=0, out_ex_add_out=0, out_sig_mul_out=0, out_zero=0
- skid contents to 0.
REQ-019 Reset asserted mid-transfer SHALL discard all held payloads.
REQ-020 The first in_fire SHALL be accepted on the first rising edge after resetn deasserts.

Structure
REQ-021 The state encoding (EMPTY/BUSY/FULL) and the default EXP_W/PROD_W constants SHALL reside in shared package fp_mac_pkg.
REQ-022 The state machine SHALL be placed in one sub-module, fp_mac_skid_ctrl, which outputs load_main, load_skid and skid_to_main.
REQ-023 Datapath registers SHALL remain in fp_mac_pipe_stage.

Verification
REQ-024 Reset check: resetn=0 mid-stream -> out_valid=0, in_ready=1, and all outputs 0 immediately (asynchronous).
REQ-025 Streaming check: in_valid=1 with out_ready=1, 5 payloads with ex=8'h10..8'h14 -> same values out in order, one per cycle, 1-cycle latency.
REQ-026 Backpressure check: out_ready=0 while 3 payloads (ex 8'h01, 8'h02, 8'h03) are offered ->
- first two accepted and in_ready=0 after the second
- outputs hold 8'h01
- releasing out_ready yields 8'h01, 8'h02, then 8'h03 is accepted.
REQ-027 Flush check: flush=1 in FULL with in_valid=1 -> next cycle EMPTY, out_valid=0, and no held or incoming payload ever appears.
REQ-028 Zero-flag check: sig=22'h0 -> out_zero=1; sig=22'h000001 -> out_zero=0; each flag stays aligned with its payload through the skid path.

Source files
------------

// File: rtl/fp_mac_pkg.sv
// Shared constants and state encoding for the FP MAC pipeline stage.
package fp_mac_pkg;

    localparam int unsigned EXP_W_DEF  = 8;
    localparam int unsigned PROD_W_DEF = 22;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/fp_mac_skid_ctrl.sv
// Control FSM for the two-entry skid buffer. It sequences loads into the main and skid registers.
module fp_mac_skid_ctrl
    import fp_mac_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load_main,
    output logic load_skid,
    output logic skid_to_main
);

    skid_state_e state_q;
    skid_state_e state_d;
    logic        in_fire;
    logic        out_fire;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake readiness depends on the state register only, so there is no ready/valid loop.
    always_comb begin
        in_fire  = in_valid  & (state_q != ST_FULL);
        out_fire = out_ready & (state_q != ST_EMPTY);
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (in_fire) state_d = ST_BUSY;
                ST_BUSY: begin
                    if (in_fire && !out_fire) begin
                        state_d = ST_FULL;
                    end else if (!in_fire && out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL:  if (out_fire) state_d = ST_BUSY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                in_ready  = 1'b1;
                load_main = in_fire & ~flush;
            end
            ST_BUSY: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                load_main = in_fire & out_fire & ~flush;
                load_skid = in_fire & ~out_fire & ~flush;
            end
            ST_FULL: begin
                out_valid    = 1'b1;
                skid_to_main = out_fire & ~flush;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fp_mac_pipe_stage.sv
// Registered pipeline stage between the FP MAC multiply and normalise steps.
// Payloads pass through a two-entry skid buffer with a captured product-is-zero flag.
module fp_mac_pipe_stage
    import fp_mac_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned PROD_W = PROD_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_out_sign,
    input  logic [EXP_W-1:0]  in_ex_add_out,
    input  logic [PROD_W-1:0] in_sig_mul_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_out_sign,
    output logic [EXP_W-1:0]  out_ex_add_out,
    output logic [PROD_W-1:0] out_sig_mul_out,
    output logic              out_zero
);

    logic load_main;
    logic load_skid;
    logic skid_to_main;
    logic in_zero;

    logic              main_sign_q, main_sign_d;
    logic [EXP_W-1:0]  main_ex_q,   main_ex_d;
    logic [PROD_W-1:0] main_sig_q,  main_sig_d;
    logic              main_zero_q, main_zero_d;

    logic              skid_sign_q, skid_sign_d;
    logic [EXP_W-1:0]  skid_ex_q,   skid_ex_d;
    logic [PROD_W-1:0] skid_sig_q,  skid_sig_d;
    logic              skid_zero_q, skid_zero_d;

    fp_mac_skid_ctrl u_ctrl (
        .clock        (clock),
        .resetn       (resetn),
        .flush        (flush),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .load_main    (load_main),
        .load_skid    (load_skid),
        .skid_to_main (skid_to_main)
    );

    // The zero flag is decided at capture so it travels with its payload through either slot.
    always_comb begin
        in_zero = (in_sig_mul_out == '0);
    end

    always_comb begin
        main_sign_d = main_sign_q;
        main_ex_d   = main_ex_q;
        main_sig_d  = main_sig_q;
        main_zero_d = main_zero_q;
        if (load_main) begin
            main_sign_d = in_out_sign;
            main_ex_d   = in_ex_add_out;
            main_sig_d  = in_sig_mul_out;
            main_zero_d = in_zero;
        end else if (skid_to_main) begin
            main_sign_d = skid_sign_q;
            main_ex_d   = skid_ex_q;
            main_sig_d  = skid_sig_q;
            main_zero_d = skid_zero_q;
        end
    end

    always_comb begin
        skid_sign_d = skid_sign_q;
        skid_ex_d   = skid_ex_q;
        skid_sig_d  = skid_sig_q;
        skid_zero_d = skid_zero_q;
        if (load_skid) begin
            skid_sign_d = in_out_sign;
            skid_ex_d   = in_ex_add_out;
            skid_sig_d  = in_sig_mul_out;
            skid_zero_d = in_zero;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            main_sign_q <= 1'b0;
            main_ex_q   <= '0;
            main_sig_q  <= '0;
            main_zero_q <= 1'b0;
            skid_sign_q <= 1'b0;
            skid_ex_q   <= '0;
            skid_sig_q  <= '0;
            skid_zero_q <= 1'b0;
        end else begin
            main_sign_q <= main_sign_d;
            main_ex_q   <= main_ex_d;
            main_sig_q  <= main_sig_d;
            main_zero_q <= main_zero_d;
            skid_sign_q <= skid_sign_d;
            skid_ex_q   <= skid_ex_d;
            skid_sig_q  <= skid_sig_d;
            skid_zero_q <= skid_zero_d;
        end
    end

    assign out_out_sign    = main_sign_q;
    assign out_ex_add_out  = main_ex_q;
    assign out_sig_mul_out = main_sig_q;
    assign out_zero        = main_zero_q;

endmodule

// File: tb/tb_fp_mac_pipe_stage.sv
// Self-checking bench for fp_mac_pipe_stage: directed table, corner sequences and a queue-model random run.
module tb_fp_mac_pipe_stage;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_out_sign = 1'b0;
    logic [7:0]  in_ex_add_out = '0;
    logic [21:0] in_sig_mul_out = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_out_sign;
    logic [7:0]  out_ex_add_out;
    logic [21:0] out_sig_mul_out;
    logic        out_zero;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        fl, iv, ordy, sg;
        logic [7:0]  ex;
        logic [21:0] sig;
        logic        e_ov, e_ir, e_sg, e_zero;
        logic [7:0]  e_ex;
        logic [21:0] e_sig;
    } vec_t;

    typedef struct {
        logic        sg;
        logic [7:0]  ex;
        logic [21:0] sig;
    } pay_t;

    vec_t tbl[11];
    pay_t q[$];

    fp_mac_pipe_stage #(.EXP_W(8), .PROD_W(22)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_out_sign     (in_out_sign),
        .in_ex_add_out   (in_ex_add_out),
        .in_sig_mul_out  (in_sig_mul_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_out_sign    (out_out_sign),
        .out_ex_add_out  (out_ex_add_out),
        .out_sig_mul_out (out_sig_mul_out),
        .out_zero        (out_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic r, input logic s,
                         input logic [7:0] e, input logic [21:0] g);
        flush          = f;
        in_valid       = v;
        out_ready      = r;
        in_out_sign    = s;
        in_ex_add_out  = e;
        in_sig_mul_out = g;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic ev, input logic er);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, "_in_ready"},  32'(in_ready),  32'(er));
    endtask

    task automatic chk_data(input string tag, input logic es, input logic [7:0] ee,
                            input logic [21:0] eg, input logic ez);
        check({tag, "_sign"}, 32'(out_out_sign),    32'(es));
        check({tag, "_ex"},   32'(out_ex_add_out),  32'(ee));
        check({tag, "_sig"},  32'(out_sig_mul_out), 32'(eg));
        check({tag, "_zero"}, 32'(out_zero),        32'(ez));
    endtask

    function automatic vec_t mk(input logic iv, input logic ordy, input logic sg,
                                input logic [7:0] ex, input logic [21:0] sig,
                                input logic e_ov, input logic e_ir, input logic e_sg,
                                input logic [7:0] e_ex, input logic [21:0] e_sig, input logic e_zero);
        vec_t v;
        v.fl = 1'b0; v.iv = iv; v.ordy = ordy; v.sg = sg; v.ex = ex; v.sig = sig;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_sg = e_sg; v.e_ex = e_ex; v.e_sig = e_sig; v.e_zero = e_zero;
        return v;
    endfunction

    initial begin
        pay_t p;
        logic m_ir, m_ov, fl, iv, ordy;

        // Backpressure and zero-flag alignment; expected values are the outputs after each edge.
        tbl[0]  = mk(1, 0, 1, 8'h01, 22'h0,      1, 1, 1, 8'h01, 22'h0,      1);
        tbl[1]  = mk(1, 0, 0, 8'h02, 22'h000001, 1, 0, 1, 8'h01, 22'h0,      1);
        tbl[2]  = mk(1, 0, 0, 8'h03, 22'h000005, 1, 0, 1, 8'h01, 22'h0,      1);
        tbl[3]  = mk(1, 1, 0, 8'h03, 22'h000005, 1, 1, 0, 8'h02, 22'h000001, 0);
        tbl[4]  = mk(1, 0, 1, 8'h03, 22'h000005, 1, 0, 0, 8'h02, 22'h000001, 0);
        tbl[5]  = mk(0, 1, 0, 8'h00, 22'h0,      1, 1, 1, 8'h03, 22'h000005, 0);
        tbl[6]  = mk(0, 1, 0, 8'h00, 22'h0,      0, 1, 0, 8'h00, 22'h0,      0);
        tbl[7]  = mk(1, 0, 0, 8'h04, 22'h000001, 1, 1, 0, 8'h04, 22'h000001, 0);
        tbl[8]  = mk(1, 0, 1, 8'h05, 22'h0,      1, 0, 0, 8'h04, 22'h000001, 0);
        tbl[9]  = mk(0, 1, 0, 8'h00, 22'h0,      1, 1, 1, 8'h05, 22'h0,      1);
        tbl[10] = mk(0, 1, 0, 8'h00, 22'h0,      0, 1, 0, 8'h00, 22'h0,      0);

        #1;
        chk_flags("por", 1'b0, 1'b1);
        chk_data("por", 1'b0, 8'h00, 22'h0, 1'b0);
        step();
        resetn = 1'b1;

        // Streaming: first payload accepted on the first edge after reset release.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, i[0], 8'h10 + 8'(i), 22'(i + 1));
            step();
            chk_flags($sformatf("stream%0d", i), 1'b1, 1'b1);
            chk_data($sformatf("stream%0d", i), i[0], 8'h10 + 8'(i), 22'(i + 1), 1'b0);
        end
        drive(0, 0, 1, 0, 8'h00, 22'h0);
        step();
        chk_flags("stream_drain", 1'b0, 1'b1);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].sg, tbl[i].ex, tbl[i].sig);
            step();
            chk_flags($sformatf("tbl%0d", i), tbl[i].e_ov, tbl[i].e_ir);
            if (tbl[i].e_ov)
                chk_data($sformatf("tbl%0d", i), tbl[i].e_sg, tbl[i].e_ex, tbl[i].e_sig, tbl[i].e_zero);
        end

        // Flush while FULL with a same-cycle offer: everything held or offered is dropped.
        drive(0, 1, 0, 1, 8'hA1, 22'h00_1111);
        step();
        drive(0, 1, 0, 0, 8'hA2, 22'h00_2222);
        step();
        chk_flags("fl_full", 1'b1, 1'b0);
        drive(1, 1, 0, 1, 8'hA3, 22'h00_3333);
        step();
        chk_flags("fl_now", 1'b0, 1'b1);
        chk_data("fl_keep", 1'b1, 8'hA1, 22'h00_1111, 1'b0);
        drive(0, 0, 1, 0, 8'h00, 22'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_flags($sformatf("fl_idle%0d", i), 1'b0, 1'b1);
        end
        drive(0, 1, 1, 0, 8'hB0, 22'h0);
        step();
        chk_flags("fl_next", 1'b1, 1'b1);
        chk_data("fl_next", 1'b0, 8'hB0, 22'h0, 1'b1);
        drive(0, 0, 1, 0, 8'h00, 22'h0);
        step();
        chk_flags("fl_after", 1'b0, 1'b1);

        // Asynchronous reset in the middle of a cycle with both slots occupied.
        drive(0, 1, 0, 1, 8'hC1, 22'h3F_FFFF);
        step();
        drive(0, 1, 0, 1, 8'hC2, 22'h12_3456);
        step();
        chk_flags("rst_full", 1'b1, 1'b0);
        drive(0, 0, 1, 0, 8'h00, 22'h0);
        #2;
        resetn = 1'b0;
        #1;
        chk_flags("rst_async", 1'b0, 1'b1);
        chk_data("rst_async", 1'b0, 8'h00, 22'h0, 1'b0);
        step();
        resetn = 1'b1;
        step();
        chk_flags("rst_discard", 1'b0, 1'b1);

        // Random traffic against an ordered queue of capacity two.
        q.delete();
        for (int n = 0; n < 400; n++) begin
            fl   = ($urandom_range(0, 19) == 0);
            iv   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            p.sg  = 1'($urandom_range(0, 1));
            p.ex  = 8'($urandom);
            p.sig = ($urandom_range(0, 3) == 0) ? 22'h0 : 22'($urandom);
            drive(fl, iv, ordy, p.sg, p.ex, p.sig);
            m_ir = (q.size() < 2);
            m_ov = (q.size() > 0);
            chk_flags("rnd_pre", m_ov, m_ir);
            step();
            if (fl) begin
                q.delete();
            end else begin
                if (m_ov && ordy) void'(q.pop_front());
                if (iv && m_ir) q.push_back(p);
            end
            check("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0)
                chk_data("rnd", q[0].sg, q[0].ex, q[0].sig, q[0].sig == 22'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
